// File: rtl/clock_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_div_pkg
//  Description : Shared widths, divisor presets and per-edge channel ops
//                for the programmable clock-enable generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_div_pkg;

    localparam int          CNT_WIDTH_DEFAULT = 27;

    localparam int unsigned SYS_CLK_HZ        = 100_000_000;
    localparam int unsigned DIV_1HZ           = 100_000_000;
    localparam int unsigned DIV_1KHZ          = 100_000;
    localparam int unsigned DIV_DISPLAY_SCAN  = 100_000;
    localparam int unsigned DIV_DEBOUNCE      = 1_000_000;

    // What a channel does on a given edge once reset is excluded.
    typedef enum logic [1:0] {
        OP_STALL = 2'd0,
        OP_COUNT = 2'd1,
        OP_SYNC  = 2'd2,
        OP_LOAD  = 2'd3
    } ch_op_e;

    function automatic int unsigned div_for_hz(input int unsigned hz);
        return (hz == 0) ? 0 : SYS_CLK_HZ / hz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_channel.sv
`default_nettype none
// ============================================================================
//  Module      : div_channel
//  Description : One divider channel: divisor, counter, tick strobe,
//                50% div_clock and active flag with load/sync/count priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_channel
    import clock_div_pkg::*;
#(
    parameter int          CNT_WIDTH   = CNT_WIDTH_DEFAULT,
    parameter int unsigned DEFAULT_DIV = DIV_1KHZ
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_enable,
    input  logic                 i_sync,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_div_value,
    output logic                 o_tick,
    output logic                 o_div_clock,
    output logic                 o_active
);

    localparam logic [CNT_WIDTH-1:0] c_default_div = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] c_one         = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_div;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_tick;
    logic                 r_div_clock;
    logic                 r_active;

    logic                 w_div_nonzero;
    logic                 w_terminal;
    ch_op_e               w_op;

    assign w_div_nonzero = (r_div != '0);
    assign w_terminal    = (r_cnt == (r_div - c_one));

    always_comb begin
        w_op = OP_STALL;
        if (i_load) begin
            w_op = OP_LOAD;
        end else if (i_sync) begin
            w_op = OP_SYNC;
        end else if (i_enable && w_div_nonzero) begin
            w_op = OP_COUNT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div       <= c_default_div;
            r_cnt       <= '0;
            r_tick      <= 1'b0;
            r_div_clock <= 1'b0;
            r_active    <= (c_default_div != '0);
        end else begin
            case (w_op)
                OP_LOAD: begin
                    r_div       <= i_div_value;
                    r_cnt       <= '0;
                    r_tick      <= 1'b0;
                    r_div_clock <= 1'b0;
                    r_active    <= (i_div_value != '0);
                end
                OP_SYNC: begin
                    r_cnt       <= '0;
                    r_tick      <= 1'b0;
                    r_div_clock <= 1'b0;
                end
                OP_COUNT: begin
                    if (w_terminal) begin
                        r_cnt       <= '0;
                        r_tick      <= 1'b1;
                        r_div_clock <= ~r_div_clock;
                    end else begin
                        r_cnt  <= r_cnt + c_one;
                        r_tick <= 1'b0;
                    end
                end
                OP_STALL: begin
                    // Paused or disabled: hold phase, but a zero divisor pins cnt at 0.
                    r_tick <= 1'b0;
                    if (!w_div_nonzero) begin
                        r_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign o_tick      = r_tick;
    assign o_div_clock = r_div_clock;
    assign o_active    = r_active;

endmodule
`default_nettype wire

// File: rtl/clock_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clock_div_prog
//  Description : Multi-channel programmable clock-enable generator; each
//                channel divides the system clock by a runtime divisor.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter int          CHANNELS    = 4,
    parameter int          CNT_WIDTH   = CNT_WIDTH_DEFAULT,
    parameter int unsigned DEFAULT_DIV = DIV_1KHZ
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sync,
    input  logic [CHANNELS-1:0]  load,
    input  logic [CNT_WIDTH-1:0] div_value,
    output logic [CHANNELS-1:0]  tick,
    output logic [CHANNELS-1:0]  div_clock,
    output logic [CHANNELS-1:0]  active
);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        div_channel #(
            .CNT_WIDTH   (CNT_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .i_enable    (enable),
            .i_sync      (sync),
            .i_load      (load[gi]),
            .i_div_value (div_value),
            .o_tick      (tick[gi]),
            .o_div_clock (div_clock[gi]),
            .o_active    (active[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_div_prog
//  Description : Directed bench for clock_div_prog with a phase-count model
//                checked every cycle plus hand-computed spot checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_div_prog;

    localparam int          CH  = 4;
    localparam int          CW  = 27;
    localparam int unsigned DEF = 1000;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          sync;
    logic [CH-1:0] load;
    logic [CW-1:0] div_value;
    logic [CH-1:0] tick;
    logic [CH-1:0] div_clock;
    logic [CH-1:0] active;

    int n_cmp  = 0;
    int n_fail = 0;

    clock_div_prog #(
        .CHANNELS    (CH),
        .CNT_WIDTH   (CW),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .sync      (sync),
        .load      (load),
        .div_value (div_value),
        .tick      (tick),
        .div_clock (div_clock),
        .active    (active)
    );

    always #5 clock = ~clock;

    // Model: n = enabled edges since the last realign; ticks land where n is a
    // multiple of D, and div_clock is the parity of completed periods.
    int unsigned   m_div [CH];
    int unsigned   m_n   [CH];
    logic [CH-1:0] m_tick;
    logic [CH-1:0] m_dc;
    logic [CH-1:0] m_act;
    bit            m_valid = 1'b0;

    always @(posedge clock) begin
        for (int i = 0; i < CH; i++) begin
            if (reset) begin
                m_div[i]  = DEF;
                m_n[i]    = 0;
                m_tick[i] = 1'b0;
            end else if (!m_valid) begin
                m_tick[i] = 1'b0;
            end else if (load[i]) begin
                m_div[i]  = int'(div_value);
                m_n[i]    = 0;
                m_tick[i] = 1'b0;
            end else if (sync) begin
                m_n[i]    = 0;
                m_tick[i] = 1'b0;
            end else if (enable && m_div[i] != 0) begin
                m_n[i]    = m_n[i] + 1;
                m_tick[i] = (m_n[i] % m_div[i]) == 0;
            end else begin
                m_tick[i] = 1'b0;
            end
            m_dc[i]  = (m_div[i] == 0) ? 1'b0 : (((m_n[i] / m_div[i]) % 2) == 1);
            m_act[i] = (m_div[i] != 0);
        end
        if (reset) m_valid = 1'b1;
    end

    always @(negedge clock) begin
        if (m_valid) begin
            n_cmp = n_cmp + 3;
            if (tick !== m_tick) begin
                n_fail++;
                $display("FAIL model_tick t=%0t: got %b expected %b", $time, tick, m_tick);
            end
            if (div_clock !== m_dc) begin
                n_fail++;
                $display("FAIL model_div_clock t=%0t: got %b expected %b", $time, div_clock, m_dc);
            end
            if (active !== m_act) begin
                n_fail++;
                $display("FAIL model_active t=%0t: got %b expected %b", $time, active, m_act);
            end
        end
    end

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_load(input logic [CH-1:0] mask, input logic [CW-1:0] val);
        load      = mask;
        div_value = val;
        @(negedge clock);
        load      = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable = 1'b0; sync = 1'b0; load = '0; div_value = '0;
        edges(2);
        chk_vec("reset_tick", tick, 4'b0000);
        chk_vec("reset_div_clock", div_clock, 4'b0000);
        chk_vec("reset_active", active, 4'b1111);
        reset  = 1'b0;
        enable = 1'b1;

        // ch0 divide by 5
        do_load(4'b0001, 27'd5);
        edges(4);  chk_bit("d5_edge4_tick", tick[0], 1'b0);
        edges(1);  chk_bit("d5_edge5_tick", tick[0], 1'b1);
                   chk_bit("d5_edge5_dc", div_clock[0], 1'b1);
        edges(1);  chk_bit("d5_edge6_tick", tick[0], 1'b0);
        edges(4);  chk_bit("d5_edge10_tick", tick[0], 1'b1);
                   chk_bit("d5_edge10_dc", div_clock[0], 1'b0);
        edges(5);  chk_bit("d5_edge15_tick", tick[0], 1'b1);
                   chk_bit("d5_edge15_dc", div_clock[0], 1'b1);

        // ch1 divide by 1
        do_load(4'b0010, 27'd1);
        chk_bit("d1_load_dc", div_clock[1], 1'b0);
        edges(1);  chk_bit("d1_e1_tick", tick[1], 1'b1);
                   chk_bit("d1_e1_dc", div_clock[1], 1'b1);
        edges(1);  chk_bit("d1_e2_tick", tick[1], 1'b1);
                   chk_bit("d1_e2_dc", div_clock[1], 1'b0);
        edges(1);  chk_bit("d1_e3_dc", div_clock[1], 1'b1);

        // ch2 disabled by zero divisor, then re-armed with 3
        do_load(4'b0100, 27'd0);
        chk_bit("d0_active", active[2], 1'b0);
        edges(50);
        chk_bit("d0_tick", tick[2], 1'b0);
        chk_bit("d0_dc", div_clock[2], 1'b0);
        do_load(4'b0100, 27'd3);
        chk_bit("d3_active", active[2], 1'b1);
        edges(2);  chk_bit("d3_e2_tick", tick[2], 1'b0);
        edges(1);  chk_bit("d3_e3_tick", tick[2], 1'b1);

        // ch0 D=4, pause at cnt=2
        do_load(4'b0001, 27'd4);
        edges(2);
        enable = 1'b0;
        edges(7);  chk_bit("pause_tick", tick[0], 1'b0);
        enable = 1'b1;
        edges(1);  chk_bit("resume_e1_tick", tick[0], 1'b0);
        edges(1);  chk_bit("resume_e2_tick", tick[0], 1'b1);
        edges(4);  chk_bit("resume_e6_tick", tick[0], 1'b1);

        // load on the terminal-count edge
        do_load(4'b0001, 27'd4);
        edges(3);
        do_load(4'b0001, 27'd6);
        chk_bit("load_tc_tick", tick[0], 1'b0);
        chk_bit("load_tc_dc", div_clock[0], 1'b0);
        edges(5);  chk_bit("d6_e5_tick", tick[0], 1'b0);
        edges(1);  chk_bit("d6_e6_tick", tick[0], 1'b1);
                   chk_bit("d6_e6_dc", div_clock[0], 1'b1);

        // sync mid-count
        edges(3);
        sync = 1'b1;
        edges(1);
        sync = 1'b0;
        chk_vec("sync_tick", tick, 4'b0000);
        chk_vec("sync_dc", div_clock, 4'b0000);
        edges(5);  chk_bit("sync_d6_e5_tick", tick[0], 1'b0);
        edges(1);  chk_bit("sync_d6_e6_tick", tick[0], 1'b1);

        // realign, bring ch3 to cnt=700, then reset mid-period
        sync = 1'b1;
        edges(1);
        sync = 1'b0;
        edges(700);
        reset = 1'b1;
        edges(1);
        reset = 1'b0;
        chk_vec("midreset_tick", tick, 4'b0000);
        chk_vec("midreset_dc", div_clock, 4'b0000);
        chk_vec("midreset_active", active, 4'b1111);
        edges(DEF - 1);
        chk_bit("post_reset_e999_tick3", tick[3], 1'b0);
        edges(1);
        chk_vec("post_reset_e1000_tick", tick, 4'b1111);
        chk_vec("post_reset_e1000_dc", div_clock, 4'b1111);
        edges(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
